// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg: shared ALU funct codes, FSM states and opcode check for the ALU share arbiter
// Contents:
//   F_*          funct codes understood by the shared ALU
//   ALU_OP_IDLE  opcode driven to the ALU out of reset (not a supported op)
//   state_t      arbiter FSM states
//   op_supported returns 1 when the ALU implements the given funct
package alu_share_arbiter_pkg;
    localparam logic [5:0] F_SLL       = 6'b000000;
    localparam logic [5:0] F_SRL       = 6'b000010;
    localparam logic [5:0] F_SRA       = 6'b000011;
    localparam logic [5:0] F_SLLV      = 6'b000100;
    localparam logic [5:0] F_SRLV      = 6'b000110;
    localparam logic [5:0] F_SRAV      = 6'b000111;
    localparam logic [5:0] F_ADDU      = 6'b100001;
    localparam logic [5:0] F_SUBU      = 6'b100011;
    localparam logic [5:0] F_AND       = 6'b100100;
    localparam logic [5:0] F_OR        = 6'b100101;
    localparam logic [5:0] F_XOR       = 6'b100110;
    localparam logic [5:0] F_NOR       = 6'b100111;
    localparam logic [5:0] F_SLT       = 6'b101010;
    localparam logic [5:0] ALU_OP_IDLE = 6'b111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_supported(input logic [5:0] op);
        return op inside {F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
                          F_ADDU, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT};
    endfunction
endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant, combinational
// Ports:
//   req[1:0]  in   request lines
//   last      in   port granted most recently (loses a tie)
//   en        in   grant enable; no grant when low
//   gnt[1:0]  out  one-hot (or zero) grant
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);
    assign gnt[0] = en & req[0] & (~req[1] | last);
    assign gnt[1] = en & req[1] & (~req[0] | ~last);
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters with round-robin arbitration
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   r0_* / r1_*                 request channels: valid/ready, operands a/b, funct op
//   alu_a, alu_b, alu_op        registered operands/opcode to the external ALU
//   alu_result                  combinational result from the external ALU
//   s0_* / s1_*                 response channels: valid/ready, data, unsupported-op err
module alu_share_arbiter #(
    parameter int N = 31
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         r0_valid,
    output logic         r0_ready,
    input  logic [N:0]   r0_a,
    input  logic [N:0]   r0_b,
    input  logic [5:0]   r0_op,
    input  logic         r1_valid,
    output logic         r1_ready,
    input  logic [N:0]   r1_a,
    input  logic [N:0]   r1_b,
    input  logic [5:0]   r1_op,
    output logic [N:0]   alu_a,
    output logic [N:0]   alu_b,
    output logic [5:0]   alu_op,
    input  logic [N:0]   alu_result,
    output logic         s0_valid,
    input  logic         s0_ready,
    output logic [N:0]   s0_data,
    output logic         s0_err,
    output logic         s1_valid,
    input  logic         s1_ready,
    output logic [N:0]   s1_data,
    output logic         s1_err
);
    import alu_share_arbiter_pkg::*;

    state_t     state;
    logic       last_grant;
    logic       owner;
    logic [1:0] gnt;

    // Grants only while idle and out of reset, so ready never rises during reset
    rr_arb2 u_arb (
        .req  ({r1_valid, r0_valid}),
        .last (last_grant),
        .en   (state == IDLE && rst_n),
        .gnt  (gnt)
    );

    assign r0_ready = gnt[0];
    assign r1_ready = gnt[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= ALU_OP_IDLE;
            s0_valid   <= 1'b0;
            s0_data    <= '0;
            s0_err     <= 1'b0;
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|gnt) begin
                    alu_a      <= gnt[1] ? r1_a  : r0_a;
                    alu_b      <= gnt[1] ? r1_b  : r0_b;
                    alu_op     <= gnt[1] ? r1_op : r0_op;
                    owner      <= gnt[1];
                    last_grant <= gnt[1];
                    state      <= EXEC;
                end
                EXEC: begin
                    // The ALU itself returns all ones for an unsupported funct
                    if (owner) begin
                        s1_data  <= alu_result;
                        s1_err   <= ~op_supported(alu_op);
                        s1_valid <= 1'b1;
                    end else begin
                        s0_data  <= alu_result;
                        s0_err   <= ~op_supported(alu_op);
                        s0_valid <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: if (owner ? s1_ready : s0_ready) begin
                    s0_valid <= 1'b0;
                    s1_valid <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed self-checking bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        r0_valid, r0_ready, r1_valid, r1_ready;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic [5:0]  r0_op, r1_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [5:0]  alu_op;
    logic        s0_valid, s0_ready, s0_err, s1_valid, s1_ready, s1_err;
    logic [31:0] s0_data, s1_data;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.N(31)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data), .s0_err(s0_err),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data), .s1_err(s1_err)
    );

    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
        case (op)
            6'b100001: return a + b;
            6'b100011: return a - b;
            6'b100100: return a & b;
            6'b100101: return a | b;
            6'b100110: return a ^ b;
            6'b100111: return ~(a | b);
            6'b101010: return {31'd0, $signed(a) < $signed(b)};
            6'b000000: return a << b[10:6];
            6'b000010: return a >> b[10:6];
            6'b000011: return $signed(a) >>> b[10:6];
            6'b000100: return a << b[4:0];
            6'b000110: return a >> b[4:0];
            6'b000111: return $signed(a) >>> b[4:0];
            default:   return 32'hFFFFFFFF;
        endcase
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_op);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; r0_valid = 1'b1; r1_valid = 1'b1;
        r0_a = '0; r0_b = '0; r0_op = '0; r1_a = '0; r1_b = '0; r1_op = '0;
        s0_ready = 1'b1; s1_ready = 1'b1;
        step(); step();
        check("rst r0_ready", {31'd0, r0_ready}, 0);
        check("rst r1_ready", {31'd0, r1_ready}, 0);
        check("rst s0_valid", {31'd0, s0_valid}, 0);
        check("rst s1_valid", {31'd0, s1_valid}, 0);
        check("rst alu_op", {26'd0, alu_op}, 32'h3F);
        check("rst s0_data", s0_data, 0);
        r0_valid = 1'b0; r1_valid = 1'b0; rst_n = 1'b1;
        step();

        // single op on port 0: ADDU 5+7
        r0_valid = 1'b1; r0_a = 5; r0_b = 7; r0_op = 6'b100001;
        settle();
        check("single r0_ready", {31'd0, r0_ready}, 1);
        check("single r1_ready", {31'd0, r1_ready}, 0);
        step();
        r0_valid = 1'b0;
        check("single exec s0_valid", {31'd0, s0_valid}, 0);
        check("single alu_a", alu_a, 5);
        check("single alu_op", {26'd0, alu_op}, 32'h21);
        step();
        check("single s0_valid", {31'd0, s0_valid}, 1);
        check("single s0_data", s0_data, 12);
        check("single s0_err", {31'd0, s0_err}, 0);
        check("single s1_valid", {31'd0, s1_valid}, 0);
        step();
        check("single s0 cleared", {31'd0, s0_valid}, 0);

        // unsupported op on port 1 (last_grant becomes 1)
        r1_valid = 1'b1; r1_a = 1; r1_b = 1; r1_op = 6'b001000;
        settle();
        check("unsup r1_ready", {31'd0, r1_ready}, 1);
        step();
        r1_valid = 1'b0;
        step();
        check("unsup s1_valid", {31'd0, s1_valid}, 1);
        check("unsup s1_err", {31'd0, s1_err}, 1);
        check("unsup s1_data", s1_data, 32'hFFFFFFFF);
        step();

        // tie: r0 SUBU 10-3 vs r1 OR F0|0F, r0 wins after an r1 grant
        r0_valid = 1'b1; r0_a = 10; r0_b = 3; r0_op = 6'b100011;
        r1_valid = 1'b1; r1_a = 32'hF0; r1_b = 32'h0F; r1_op = 6'b100101;
        settle();
        check("tie1 r0_ready", {31'd0, r0_ready}, 1);
        check("tie1 r1_ready", {31'd0, r1_ready}, 0);
        step();
        r0_a = 32'hFF; r0_b = 32'h0F; r0_op = 6'b100110;
        check("tie exec r0_ready", {31'd0, r0_ready}, 0);
        check("tie exec r1_ready", {31'd0, r1_ready}, 0);
        step();
        check("tie s0_valid", {31'd0, s0_valid}, 1);
        check("tie s0_data", s0_data, 7);
        check("tie resp r1_ready", {31'd0, r1_ready}, 0);
        step();
        check("tie2 r1_ready", {31'd0, r1_ready}, 1);
        check("tie2 r0_ready", {31'd0, r0_ready}, 0);
        step();
        step();
        check("tie2 s1_valid", {31'd0, s1_valid}, 1);
        check("tie2 s1_data", s1_data, 32'hFF);
        check("tie2 s1_err", {31'd0, s1_err}, 0);
        r1_valid = 1'b0;
        step();
        check("tie3 r0_ready", {31'd0, r0_ready}, 1);
        step();
        r0_valid = 1'b0;
        step();
        check("tie3 s0_data", s0_data, 32'hF0);
        step();

        // backpressure on port 0 with port 1 waiting
        s0_ready = 1'b0;
        r0_valid = 1'b1; r0_a = 100; r0_b = 23; r0_op = 6'b100001;
        settle();
        check("bp r0_ready", {31'd0, r0_ready}, 1);
        step();
        r0_valid = 1'b0;
        r1_valid = 1'b1; r1_a = 32'hFF; r1_b = 32'h3C; r1_op = 6'b100100;
        settle();
        check("bp exec r1_ready", {31'd0, r1_ready}, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("bp s0_valid", {31'd0, s0_valid}, 1);
            check("bp s0_data", s0_data, 123);
            check("bp r1_ready", {31'd0, r1_ready}, 0);
            step();
        end
        s0_ready = 1'b1;
        check("bp release s0_valid", {31'd0, s0_valid}, 1);
        check("bp release r1_ready", {31'd0, r1_ready}, 0);
        step();
        check("bp idle s0_valid", {31'd0, s0_valid}, 0);
        check("bp idle r1_ready", {31'd0, r1_ready}, 1);
        step();
        r1_valid = 1'b0;
        step();
        check("bp s1_data", s1_data, 32'h3C);
        step();

        // reset during EXEC of r0 SRA 0x80000000 >>> 4
        r0_valid = 1'b1; r0_a = 32'h80000000; r0_b = 32'd4 << 6; r0_op = 6'b000011;
        settle();
        check("rmid r0_ready", {31'd0, r0_ready}, 1);
        step();
        r0_valid = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rmid alu_op", {26'd0, alu_op}, 32'h3F);
        for (int i = 0; i < 4; i++) begin
            check("rmid s0_valid", {31'd0, s0_valid}, 0);
            step();
        end
        r0_valid = 1'b1; r1_valid = 1'b1;
        settle();
        check("rmid tie r0_ready", {31'd0, r0_ready}, 1);
        check("rmid tie r1_ready", {31'd0, r1_ready}, 0);
        r0_valid = 1'b0; r1_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
